// File: rtl/module_btn_step.sv
// Push-button front end: synchronizer, stability-count debouncer and one-cycle step strobe.
// Optional auto-repeat while held is enabled by defining BTN_STEP_AUTOREPEAT_EN.
module module_btn_step #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter bit BTN_ACTIVE_LOW = 1'b0,
  parameter int HOLD_CYCLES    = 64,
  parameter int REPEAT_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic step,
  output logic btn_level
);

  localparam int CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw;
  state_t                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [CntW-1:0]        cnt_inc;
  logic                   step_q;
  logic                   level_q;

  // Stages reset to the released level so a held button is re-qualified after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{BTN_ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign raw     = sync_q[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

`ifdef BTN_STEP_AUTOREPEAT_EN
  localparam int HoldMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HoldW   = $clog2(HoldMax + 1);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] RepLast  = HoldW'(REPEAT_CYCLES - 1);

  logic [HoldW-1:0] hold_q;
  logic             repeating_q;  // after the first repeat, the period switches to REPEAT_CYCLES
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      level_q <= 1'b0;
`ifdef BTN_STEP_AUTOREPEAT_EN
      hold_q      <= '0;
      repeating_q <= 1'b0;
`endif
    end else begin
      step_q <= 1'b0;
`ifdef BTN_STEP_AUTOREPEAT_EN
      hold_q      <= '0;
      repeating_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (raw) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CntOne;
          end else begin
            cnt_q <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!raw) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            step_q  <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        PRESSED: begin
          if (!raw) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CntOne;
          end else begin
`ifdef BTN_STEP_AUTOREPEAT_EN
            if (hold_q == (repeating_q ? RepLast : HoldLast)) begin
              step_q      <= 1'b1;
              hold_q      <= '0;
              repeating_q <= 1'b1;
            end else begin
              hold_q      <= hold_q + HoldOne;
              repeating_q <= repeating_q;
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed returns silently; only a full stable release clears the level.
          if (raw) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign step      = step_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_module_btn_step.sv
// Scoreboard bench: an active-high and an active-low instance are both checked against
// a run-length reference model of the debouncer (auto-repeat modelled when the macro is set).
module tb_module_btn_step;

  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int HOLD   = 10;
  localparam int REP    = 4;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       pressed = 1'b1;
  logic [1:0] btn_w;
  logic [1:0] step_w;
  logic [1:0] level_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_dut
    assign btn_w[gi] = (gi == 1) ? ~pressed : pressed;
    module_btn_step #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STABLE),
      .BTN_ACTIVE_LOW(gi == 1),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REP)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_w[gi]),
      .step     (step_w[gi]),
      .btn_level(level_w[gi])
    );
  end

  // Reference model: the accepted level flips after STABLE consecutive equal samples of the
  // button as seen SYNC edges later; a step is expected on every acceptance of a press.
  int unsigned cyc = 0;
  bit          dl[$];
  logic        exp_lvl   = 1'b0;
  int          ones_run  = 0;
  int          zeros_run = 0;
  int unsigned exp_q[2][$];
`ifdef BTN_STEP_AUTOREPEAT_EN
  int          held_k   = 0;
  bit          prev_raw = 1'b0;
`endif

  always @(posedge clk) begin
    bit raw;
    bit fire;
    cyc++;
    if (rst) begin
      dl.delete();
      for (int i = 0; i < SYNC; i++) dl.push_back(1'b0);
      exp_lvl   = 1'b0;
      ones_run  = 0;
      zeros_run = 0;
`ifdef BTN_STEP_AUTOREPEAT_EN
      held_k   = 0;
      prev_raw = 1'b0;
`endif
    end else begin
      raw = dl.pop_front();
      dl.push_back(pressed);
      if (raw) begin
        ones_run++;
        zeros_run = 0;
      end else begin
        zeros_run++;
        ones_run = 0;
      end
      fire = 1'b0;
      if (!exp_lvl) begin
        if (ones_run >= STABLE) begin
          exp_lvl = 1'b1;
          fire    = 1'b1;
`ifdef BTN_STEP_AUTOREPEAT_EN
          held_k = 0;
`endif
        end
      end else if (raw) begin
`ifdef BTN_STEP_AUTOREPEAT_EN
        if (!prev_raw) held_k = 0;
        else begin
          held_k++;
          if (held_k == HOLD || (held_k > HOLD && (held_k - HOLD) % REP == 0)) fire = 1'b1;
        end
`endif
      end else if (zeros_run >= STABLE) begin
        exp_lvl = 1'b0;
      end
`ifdef BTN_STEP_AUTOREPEAT_EN
      prev_raw = raw;
`endif
      if (fire) begin
        exp_q[0].push_back(cyc);
        exp_q[1].push_back(cyc);
      end
    end
  end

  // Monitor: every step pulse pops the scoreboard; level is compared every cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (level_w[i] !== exp_lvl) begin
          errors++;
          $display("FAIL btn_level dut%0d cyc %0d: got %b expected %b", i, cyc, level_w[i], exp_lvl);
        end
        while (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_step dut%0d: got none at cyc %0d, expected step at cyc %0d", i, cyc, exp_q[i][0]);
          void'(exp_q[i].pop_front());
        end
        if (step_w[i] === 1'b1) begin
          checks++;
          if (exp_q[i].size() == 0 || exp_q[i][0] != cyc) begin
            errors++;
            $display("FAIL unexpected_step dut%0d: got step at cyc %0d, expected next at %0d", i, cyc,
                     (exp_q[i].size() == 0) ? 0 : exp_q[i][0]);
          end else begin
            void'(exp_q[i].pop_front());
            $display("step dut%0d at cyc %0d matches scoreboard", i, cyc);
          end
        end else if (step_w[i] !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL step_unknown dut%0d cyc %0d: got %b expected 0/1", i, cyc, step_w[i]);
        end
      end
    end
  end

  task automatic hold(input bit v, input int n);
    pressed = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Button held through a 3-cycle reset.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 30);
    hold(1'b0, 30);
    // Clean 40-cycle press.
    hold(1'b1, 40);
    hold(1'b0, 30);
    // Press bounce, then solid high.
    repeat (5) begin
      hold(1'b1, 3);
      hold(1'b0, 2);
    end
    hold(1'b1, 30);
    hold(1'b0, 30);
    // Release glitches while pressed.
    hold(1'b1, 30);
    repeat (4) begin
      hold(1'b0, 3);
      hold(1'b1, 6);
    end
    hold(1'b0, 30);
    // Long hold (exercises repeats when auto-repeat is built in).
    hold(1'b1, STABLE + SYNC + 30);
    hold(1'b0, 30);
    // Reset while the button is held.
    hold(1'b1, 25);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 30);
    hold(1'b0, 30);
    // Randomized bursts of press/release segments with occasional reset.
    repeat (200) begin
      bit v;
      int n;
      v = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(1, 18));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      hold(v, n);
    end
    hold(1'b0, 40);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL leftover_steps dut%0d: got %0d unmatched, expected 0", i, exp_q[i].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
